mux_n_pipe: RTL

- Parametrised successor of the 2^N:1 single-bit mux tree.
- Selects one W-bit word from 2^N input words using an N-bit select.
- Built as an N-level tree of W-bit 2:1 muxes, with optional pipeline registers after any level.
- Carries a valid/ready handshake with per-stage backpressure, so it drops into streaming datapaths (crossbar ports, register-read muxes).

---
 rtl/mux_pkg.sv | 26 ++
 rtl/mux2_w.sv | 13 +
 rtl/mux_n_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared helpers for the pipelined 2^N:1 word mux: stage count and the
// layout of the flattened per-level word array.
package mux_pkg;

    // Number of register stages: set bits among the low n bits of the mask.
    function automatic int popcount(input logic [31:0] mask, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (mask[i]) c++;
        end
        return c;
    endfunction

    // Words produced by tree level l of an n-level tree.
    function automatic int level_words(input int n, input int l);
        return 1 << (n - 1 - l);
    endfunction

    // Word offset of layer k in the flat array. Layer 0 is the input set
    // (2^n words); layer k (k >= 1) is the output of level k-1.
    function automatic int layer_off(input int n, input int k);
        return (1 << (n + 1)) - (1 << (n + 1 - k));
    endfunction

endpackage

// File: rtl/mux2_w.sv
// W-bit 2:1 multiplexer, the leaf cell of the select tree.
module mux2_w #(
    parameter int W = 8
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined 2^N:1 word mux with valid/ready flow control. Level l of the
// tree resolves select bit l; a register stage with backpressure can follow
// any level. For N=0 the select ports shrink to a single unused bit that is
// simply passed through.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int          N         = 3,
    parameter int          W         = 8,
    parameter logic [31:0] PIPE_MASK = 32'b101
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W*(2**N)-1:0]           in_data,
    input  logic [((N > 0) ? N : 1)-1:0]  in_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_data,
    output logic [((N > 0) ? N : 1)-1:0]  out_sel
);

    localparam int SW      = (N > 0) ? N : 1;
    localparam int L       = popcount(PIPE_MASK, N);
    localparam bit PIPED   = (L > 0);
    localparam int TOT     = (2 ** (N + 1)) - 1;
    localparam int OUT_OFF = layer_off(N, N) * W;

    // Per-layer view after any register stage: data words, valid, select,
    // and the ready seen by whatever consumes that layer.
    logic [TOT*W-1:0] post_d;
    logic             post_v   [0:N];
    logic [SW-1:0]    post_sel [0:N];
    logic             rdy      [0:N];

    assign post_d[0 +: (2**N)*W] = in_data;
    assign post_v[0]             = in_valid;
    assign post_sel[0]           = in_sel;
    assign rdy[N]                = out_ready;

    for (genvar l = 0; l < N; l++) begin : g_lvl
        localparam int LW   = level_words(N, l);
        localparam int IOFF = layer_off(N, l) * W;
        localparam int OOFF = layer_off(N, l + 1) * W;

        logic [LW*W-1:0] comb;

        for (genvar j = 0; j < LW; j++) begin : g_mux
            mux2_w #(.W(W)) u_mux (
                .in0 (post_d[IOFF + (2*j)*W   +: W]),
                .in1 (post_d[IOFF + (2*j+1)*W +: W]),
                .sel (post_sel[l][l]),
                .out (comb[j*W +: W])
            );
        end

        if (PIPE_MASK[l]) begin : g_reg
            logic            vld_p;
            logic [LW*W-1:0] data_p;
            logic [SW-1:0]   sel_p;
            logic            ld_p;

            // Stage may load when empty or when its contents move on this edge.
            assign ld_p = !vld_p || rdy[l+1];

            // Stage register: take upstream word set (or bubble) when ready, else hold.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p  <= 1'b0;
                    data_p <= '0;
                    sel_p  <= '0;
                end else if (ld_p) begin
                    vld_p  <= post_v[l];
                    data_p <= comb;
                    sel_p  <= post_sel[l];
                end
            end

            assign rdy[l]                  = ld_p;
            assign post_v[l+1]             = vld_p;
            assign post_sel[l+1]           = sel_p;
            assign post_d[OOFF +: LW*W]    = data_p;
        end else begin : g_wire
            assign rdy[l]                  = rdy[l+1];
            assign post_v[l+1]             = post_v[l];
            assign post_sel[l+1]           = post_sel[l];
            assign post_d[OOFF +: LW*W]    = comb;
        end
    end

    // While reset is held the pipe is being flushed: present nothing and
    // accept freely (accepted words are discarded by the reset itself).
    assign out_valid = post_v[N] && !(rst && PIPED);
    assign in_ready  = rdy[0] || (rst && PIPED);
    assign out_data  = post_d[OUT_OFF +: W];
    assign out_sel   = post_sel[N];

endmodule
